// File: rtl/execute_muldiv_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
// Imported by the unit and by its restoring-divide core.
package execute_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_t;

  localparam int DIV_ITERS = 32;

  function automatic logic is_signed_op(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/execute_muldiv_div.sv
// Iterative unsigned restoring divider: one quotient bit per step, DIV_ITERS steps.
// Outputs are the values after the current step so the caller can register them on the last step.
module div_restoring
  import execute_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        last_o
);

  localparam int CW = $clog2(DIV_ITERS);

  logic [32:0]   rem_q, rem_d;
  logic [31:0]   quot_q, quot_d;
  logic [31:0]   dvsr_q, dvsr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [33:0] minuend;
  logic [33:0] diff;
  logic [32:0] step_rem;
  logic [31:0] step_quot;

  // Partial remainder stays below the divisor, so diff[33] is a clean borrow flag.
  always_comb begin
    minuend   = {rem_q, quot_q[31]};
    diff      = minuend - {2'b00, dvsr_q};
    step_rem  = diff[33] ? minuend[32:0] : diff[32:0];
    step_quot = {quot_q[30:0], ~diff[33]};
  end

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
      dvsr_d = divisor_i;
      cnt_d  = '0;
    end else if (step_i) begin
      rem_d  = step_rem;
      quot_d = step_quot;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot_o = step_quot;
  assign rem_o  = 32'(step_rem);
  assign last_o = step_i && (cnt_q == CW'(DIV_ITERS - 1));

endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the execute stage; stalls E while busy
// and presents the 64-bit result on hi/lo for one instruction at a time.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        e_stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  md_state_t state_q, state_d;

  md_op_t      op_q;
  logic [31:0] a_mag_q, b_mag_q;
  logic        sign_quot_q, sign_rem_q;
  logic [MCW-1:0] mul_cnt_q, mul_cnt_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        accept, finish, mul_last;
  logic        div_load, div_step, div_last;
  logic [31:0] a_mag, b_mag;
  logic [31:0] div_quot, div_rem;
  logic [63:0] prod, prod_s;
  logic [31:0] quot_s, rem_s;

  assign a_mag    = is_signed_op(op) ? abs32(a) : a;
  assign b_mag    = is_signed_op(op) ? abs32(b) : b;
  assign mul_last = (state_q == S_MUL) && (mul_cnt_q == MCW'(MUL_CYCLES - 1));

  div_restoring u_div (
    .clk        (clk),
    .reset      (reset),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quot_o     (div_quot),
    .rem_o      (div_rem),
    .last_o     (div_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = is_div_op(op) ? S_DIV : S_MUL;
      S_MUL:   if (mul_last) state_d = S_DONE;
      S_DIV:   if (div_last) state_d = S_DONE;
      S_DONE:  if (!e_stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    accept   = (state_q == S_IDLE) && start && !flush;
    busy     = !reset && (accept || (state_q == S_MUL) || (state_q == S_DIV));
    finish   = (state_q != S_DONE) && (state_d == S_DONE);
    div_load = accept && is_div_op(op);
    div_step = (state_q == S_DIV);
    done_d   = (state_d == S_DONE);
  end

  // Counter restarts whenever MUL is left, including on flush.
  always_comb begin
    mul_cnt_d = '0;
    if ((state_q == S_MUL) && !mul_last && !flush) mul_cnt_d = mul_cnt_q + 1'b1;
  end

  always_comb begin
    prod   = {32'd0, a_mag_q} * {32'd0, b_mag_q};
    prod_s = sign_quot_q ? (64'd0 - prod) : prod;
    quot_s = sign_quot_q ? (32'd0 - div_quot) : div_quot;
    rem_s  = sign_rem_q ? (32'd0 - div_rem) : div_rem;
    if (is_div_op(op_q)) {hi_d, lo_d} = {rem_s, quot_s};
    else                 {hi_d, lo_d} = prod_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= MD_MULT;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      sign_quot_q <= 1'b0;
      sign_rem_q  <= 1'b0;
      mul_cnt_q   <= '0;
      done_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      if (accept) begin
        op_q        <= op;
        a_mag_q     <= a_mag;
        b_mag_q     <= b_mag;
        sign_quot_q <= is_signed_op(op) && (a[31] ^ b[31]);
        sign_rem_q  <= is_signed_op(op) && a[31];
      end
      mul_cnt_q <= mul_cnt_d;
      done_q    <= done_d;
      if (finish) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
